// File: rtl/scan_test_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_ctrl_if
// Purpose  : Bundles the request/result and scan-chain signals of the
//            scan-test sequencer.
//            master : host side. Drives start/abort/pattern/expected and
//                     returns the chain's scan_out on scan_so.
//            slave  : the sequencer itself.
// Signals  : start, abort, pattern[CHAIN_LEN], expected[CHAIN_LEN], scan_so
//            (host -> sequencer); scan_en, scan_si, busy, done,
//            response[CHAIN_LEN], pass, pattern_cnt[CNT_W], fail_cnt[CNT_W]
//            (sequencer -> host)
// Revision : 1.0  initial release
// ============================================================================
interface scan_test_ctrl_if #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic                 abort;
    logic [CHAIN_LEN-1:0] pattern;
    logic [CHAIN_LEN-1:0] expected;
    logic                 scan_so;
    logic                 scan_en;
    logic                 scan_si;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] response;
    logic                 pass;
    logic [CNT_W-1:0]     pattern_cnt;
    logic [CNT_W-1:0]     fail_cnt;

    modport master (
        output start, abort, pattern, expected, scan_so,
        input  scan_en, scan_si, busy, done, response, pass, pattern_cnt, fail_cnt
    );

    modport slave (
        input  start, abort, pattern, expected, scan_so,
        output scan_en, scan_si, busy, done, response, pass, pattern_cnt, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_test_ctrl
// Purpose  : Scan-test sequencer placed directly upstream of a scan chain.
//            Each accepted start runs one pattern: shift the stimulus in,
//            capture for CAP_CYCLES functional clocks, shift the response
//            out and compare it against the expected value. Keeps saturating
//            counts of completed and failing runs.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - scan_test_ctrl_if.slave (start/abort/pattern/expected/
//                     scan_so in; scan_en/scan_si/busy/done/response/pass/
//                     pattern_cnt/fail_cnt out, all registered)
// Revision : 1.0  initial release
// ============================================================================
module scan_test_ctrl #(
    parameter int CHAIN_LEN  = 4,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    scan_test_ctrl_if.slave    bus
);

    // One counter serves the SHIFT, CAPTURE and UNLOAD phases.
    localparam int c_cnt_top = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
    localparam int c_cnt_w   = (c_cnt_top > 1) ? $clog2(c_cnt_top) : 1;

    localparam logic [c_cnt_w-1:0] c_shift_last = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cap_last   = c_cnt_w'(CAP_CYCLES - 1);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_shift   = 3'd1;
    localparam logic [2:0] c_capture = 3'd2;
    localparam logic [2:0] c_unload  = 3'd3;
    localparam logic [2:0] c_done    = 3'd4;

    logic [2:0]           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_scan_en;
    logic                 r_scan_si;
    logic                 r_busy;
    logic                 r_done;
    logic [CHAIN_LEN-1:0] r_response;
    logic                 r_pass;
    logic [CNT_W-1:0]     r_pattern_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;

    // scan_so is sampled before the chain moves, so the final unload edge
    // already sees the complete response; the verdict is formed from it.
    logic [CHAIN_LEN-1:0] w_resp_next;
    logic                 w_pass_next;

    assign w_resp_next = {r_response[CHAIN_LEN-2:0], bus.scan_so};
    assign w_pass_next = (w_resp_next == r_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_expected    <= '0;
            r_scan_en     <= 1'b0;
            r_scan_si     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_response    <= '0;
            r_pass        <= 1'b0;
            r_pattern_cnt <= '0;
            r_fail_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != c_idle) && bus.abort) begin
                r_state   <= c_idle;
                r_cnt     <= '0;
                r_scan_en <= 1'b0;
                r_scan_si <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_idle: begin
                        if (bus.start && !bus.abort) begin
                            // MSB goes out first so it travels to the far end.
                            r_state    <= c_shift;
                            r_cnt      <= '0;
                            r_shreg    <= {bus.pattern[CHAIN_LEN-2:0], 1'b0};
                            r_expected <= bus.expected;
                            r_pass     <= 1'b0;
                            r_scan_en  <= 1'b1;
                            r_scan_si  <= bus.pattern[CHAIN_LEN-1];
                            r_busy     <= 1'b1;
                        end
                    end
                    c_shift: begin
                        if (r_cnt == c_shift_last) begin
                            r_state   <= c_capture;
                            r_cnt     <= '0;
                            r_scan_en <= 1'b0;
                            r_scan_si <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_scan_si <= r_shreg[CHAIN_LEN-1];
                            r_shreg   <= {r_shreg[CHAIN_LEN-2:0], 1'b0};
                        end
                    end
                    c_capture: begin
                        if (r_cnt == c_cap_last) begin
                            r_state   <= c_unload;
                            r_cnt     <= '0;
                            r_scan_en <= 1'b1;
                            r_scan_si <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_unload: begin
                        r_response <= w_resp_next;
                        if (r_cnt == c_shift_last) begin
                            r_state   <= c_done;
                            r_cnt     <= '0;
                            r_scan_en <= 1'b0;
                            r_done    <= 1'b1;
                            r_pass    <= w_pass_next;
                            if (!(&r_pattern_cnt)) begin
                                r_pattern_cnt <= r_pattern_cnt + 1'b1;
                            end
                            if (!w_pass_next && !(&r_fail_cnt)) begin
                                r_fail_cnt <= r_fail_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_done: begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state   <= c_idle;
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                        r_scan_si <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.scan_en     = r_scan_en;
    assign bus.scan_si     = r_scan_si;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.response    = r_response;
    assign bus.pass        = r_pass;
    assign bus.pattern_cnt = r_pattern_cnt;
    assign bus.fail_cnt    = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_test_ctrl
// Purpose  : Self-checking bench for scan_test_ctrl with a 4-flop scan chain
//            model (functional d driven by the bench, reset on rst_n low).
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_test_ctrl;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] exp_v;
        logic [3:0] dv;
        logic [3:0] resp;
        logic       pass;
        logic [7:0] pc;
        logic [7:0] fc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0] r_chain_q;
    logic [3:0] r_chain_d;

    int checks   = 0;
    int failures = 0;

    scan_test_ctrl_if #(.CHAIN_LEN(4), .CNT_W(8)) bus ();

    scan_test_ctrl #(
        .CHAIN_LEN  (4),
        .CAP_CYCLES (1),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scan chain: scan_si enters flop 0, flop 3 drives scan_so.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_chain_q <= 4'b0000;
        else if (bus.scan_en) r_chain_q <= {r_chain_q[2:0], bus.scan_si};
        else                 r_chain_q <= r_chain_d;
    end
    assign bus.scan_so = r_chain_q[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_scan_en"},  32'(bus.scan_en),     0);
        chk({tag, "_scan_si"},  32'(bus.scan_si),     0);
        chk({tag, "_busy"},     32'(bus.busy),        0);
        chk({tag, "_done"},     32'(bus.done),        0);
        chk({tag, "_pass"},     32'(bus.pass),        0);
        chk({tag, "_response"}, 32'(bus.response),    0);
        chk({tag, "_pcnt"},     32'(bus.pattern_cnt), 0);
        chk({tag, "_fcnt"},     32'(bus.fail_cnt),    0);
    endtask

    // One full run starting from IDLE. Cycle 1 is the cycle after the
    // accepting edge; done is expected in cycle 10.
    task automatic run_vec(input vec_t v, input bit do_chk, input bit noisy);
        int         cyc;
        int         busy_n;
        bit         seen;
        logic [3:0] si_seq;
        logic [3:0] q5;
        @(negedge clk);
        bus.pattern  = v.pat;
        bus.expected = v.exp_v;
        r_chain_d    = v.dv;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc    = 1;
        busy_n = 0;
        seen   = 1'b0;
        si_seq = 4'b0000;
        q5     = 4'b0000;
        while (!seen && cyc <= 40) begin
            if (bus.busy) busy_n++;
            if (cyc <= 4) si_seq[4-cyc] = bus.scan_si;
            if (cyc == 5) q5 = r_chain_q;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (noisy) bus.start = (cyc == 2) || (cyc == 5) || (cyc == 8);
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        if (do_chk || !seen) chk("done_seen", 32'(seen), 1);
        if (do_chk) begin
            chk("latency",     32'(cyc),             10);
            chk("busy_cycles", 32'(busy_n),          10);
            chk("si_sequence", 32'(si_seq),          32'(v.pat));
            chk("chain_load",  32'(q5),              32'(v.pat));
            chk("response",    32'(bus.response),    32'(v.resp));
            chk("pass",        32'(bus.pass),        32'(v.pass));
            chk("pattern_cnt", 32'(bus.pattern_cnt), 32'(v.pc));
            chk("fail_cnt",    32'(bus.fail_cnt),    32'(v.fc));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v_after_abort;
        vec_t v_noisy;
        vec_t v_sat_fail;
        vec_t v_sat_pass;
        bit   extra;

        vecs[0] = '{pat:4'b1011, exp_v:4'b0110, dv:4'b0110, resp:4'b0110, pass:1'b1, pc:8'd1, fc:8'd0};
        vecs[1] = '{pat:4'b0101, exp_v:4'b1010, dv:4'b1100, resp:4'b1100, pass:1'b0, pc:8'd2, fc:8'd1};
        vecs[2] = '{pat:4'b1111, exp_v:4'b0000, dv:4'b0000, resp:4'b0000, pass:1'b1, pc:8'd3, fc:8'd1};
        vecs[3] = '{pat:4'b0000, exp_v:4'b1001, dv:4'b1001, resp:4'b1001, pass:1'b1, pc:8'd4, fc:8'd1};
        vecs[4] = '{pat:4'b1000, exp_v:4'b1000, dv:4'b0001, resp:4'b0001, pass:1'b0, pc:8'd5, fc:8'd2};
        v_after_abort = '{pat:4'b0110, exp_v:4'b0101, dv:4'b0101, resp:4'b0101, pass:1'b1, pc:8'd6, fc:8'd2};
        v_noisy       = '{pat:4'b1001, exp_v:4'b0011, dv:4'b0011, resp:4'b0011, pass:1'b1, pc:8'd7, fc:8'd2};
        v_sat_fail    = '{pat:4'b0000, exp_v:4'b0000, dv:4'b1111, resp:4'b1111, pass:1'b0, pc:8'd255, fc:8'd255};
        v_sat_pass    = '{pat:4'b0101, exp_v:4'b0000, dv:4'b0000, resp:4'b0000, pass:1'b1, pc:8'd255, fc:8'd255};

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.pattern  = 4'b0000;
        bus.expected = 4'b0000;
        r_chain_d    = 4'b0000;

        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // abort together with start in IDLE: abort wins
        @(negedge clk);
        bus.pattern = 4'b1111;
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle_abort_busy",    32'(bus.busy),    0);
        chk("idle_abort_scan_en", 32'(bus.scan_en), 0);

        // Table-driven runs, back to back
        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1, 1'b0);

        // Abort during the second UNLOAD cycle
        @(negedge clk);
        bus.pattern  = 4'b1100;
        bus.expected = 4'b1010;
        r_chain_d    = 4'b1010;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_scan_en", 32'(bus.scan_en), 0);
        chk("abort_scan_si", 32'(bus.scan_si), 0);
        chk("abort_busy",    32'(bus.busy),    0);
        extra = 1'b0;
        repeat (12) begin
            if (bus.done || bus.busy) extra = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(extra),           0);
        chk("abort_pcnt",    32'(bus.pattern_cnt), 5);
        chk("abort_fcnt",    32'(bus.fail_cnt),    2);
        chk("abort_resp",    32'(bus.response),    32'(4'b0011));
        chk("abort_pass",    32'(bus.pass),        0);
        run_vec(v_after_abort, 1'b1, 1'b0);

        // Start pulses while busy must not trigger a second run
        run_vec(v_noisy, 1'b1, 1'b1);
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy || bus.done) extra = 1'b1;
        end
        chk("no_second_run", 32'(extra), 0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        bus.pattern  = 4'b1111;
        bus.expected = 4'b0000;
        r_chain_d    = 4'b0000;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("midshift_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 0);

        // Counter saturation
        for (int n = 0; n < 255; n++) run_vec(v_sat_fail, 1'b0, 1'b0);
        chk("sat_pcnt_255", 32'(bus.pattern_cnt), 255);
        chk("sat_fcnt_255", 32'(bus.fail_cnt),    255);
        run_vec(v_sat_fail, 1'b1, 1'b0);
        run_vec(v_sat_pass, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
